sapato_baralho: RTL and testbench

Multi-deck card shoe for the blackjack datapath: holds `NUM_DECKS` × 52 card values and shuffles them with an in-place Fisher-Yates permutation driven by an internal 16-bit LFSR. It serves cards sequentially through a request/valid deal port, so the scoring logic no longer computes addresses. It sits between the blackjack control FSM (shuffle request, low-shoe monitoring) and the scoring block (card consumer).

---
 rtl/sapato_baralho.sv | 230 +++++++++++++++++++++++
 tb/tb_sapato_baralho.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sapato_baralho.sv
// ---------------------------------------------------------------------------
// sapato_baralho
//
// Multi-deck card shoe for the blackjack datapath. Holds NUM_DECKS x 52 card
// values, refills them in canonical order and shuffles them in place with a
// Fisher-Yates permutation driven by an internal 16-bit Galois LFSR. Cards
// are then served in order through a request/valid deal port.
//
// Parameters:
//   NUM_DECKS      : number of 52-card decks (1..4), DEPTH = 52 * NUM_DECKS
//   SHUFFLE_PASSES : full Fisher-Yates passes per shuffle (1..4)
//   LFSR_SEED      : non-zero LFSR value loaded on reset
//   RESHUFFLE_MARK : low_shoe threshold in cards remaining
//
// Ports:
//   clock         in  : single clock, rising edge
//   reset         in  : asynchronous, active-high reset
//   shuffle_start in  : pulse requesting a refill and shuffle (IDLE only)
//   shuffle_busy  out : high while the refill/shuffle is in progress
//   shuffle_done  out : one-cycle pulse in the final busy cycle
//   deal_req      in  : request for the next card (IDLE only)
//   deal_valid    out : one-cycle pulse, deal_card valid in this cycle
//   deal_card     out : card value (1 = ace, 2..10, 11 = J/Q/K)
//   cards_left    out : number of undealt cards, 0..DEPTH
//   deal_empty    out : cards_left == 0
//   low_shoe      out : 0 < cards_left <= RESHUFFLE_MARK
// ---------------------------------------------------------------------------
module sapato_baralho #(
    parameter int          NUM_DECKS      = 1,
    parameter int          SHUFFLE_PASSES = 1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          RESHUFFLE_MARK = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       shuffle_start,
    output logic       shuffle_busy,
    output logic       shuffle_done,
    input  logic       deal_req,
    output logic       deal_valid,
    output logic [3:0] deal_card,
    output logic [7:0] cards_left,
    output logic       deal_empty,
    output logic       low_shoe
);

    localparam int         DEPTH     = 52 * NUM_DECKS;
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [7:0] DEPTH_V   = 8'(DEPTH);
    localparam logic [7:0] LAST_IDX  = 8'(DEPTH - 1);
    localparam logic [7:0] MARK      = 8'(RESHUFFLE_MARK);
    localparam logic [1:0] LAST_PASS = 2'(SHUFFLE_PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PICK,
        S_SWAP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [7:0]  idx;
    logic [AW-1:0] j_sel;
    logic [1:0]  pass;
    logic [3:0]  fill_r;
    logic [7:0]  ptr;
    logic [3:0]  mem [DEPTH];

    logic [7:0]  cand;
    logic        accept;
    logic [3:0]  canon_value;
    logic        deal_fire;

    // Smallest 2^k-1 that covers v: smear the top set bit downwards.
    function automatic logic [7:0] mask_for(input logic [7:0] v);
        logic [7:0] m;
        m = v | (v >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

    // Candidate swap partner; values above i are rejected and retried with
    // the next LFSR value, which keeps the choice unbiased.
    assign cand   = lfsr[7:0] & mask_for(idx);
    assign accept = (cand <= idx);

    // fill_r tracks slot mod 13 so no divider is needed during FILL.
    assign canon_value = (fill_r == 4'd0) ? 4'd1 :
                         (fill_r <= 4'd9) ? (fill_r + 4'd1) : 4'd11;

    // shuffle_start has priority over dealing in the same IDLE cycle.
    assign deal_fire = (state == S_IDLE) && !shuffle_start && deal_req &&
                       (cards_left != 8'd0);

    assign deal_empty = (cards_left == 8'd0);
    assign low_shoe   = (cards_left <= MARK) && (cards_left != 8'd0);

    // Free-running LFSR: it advances in every state so the shuffle outcome
    // depends on how many cycles elapsed since reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        shuffle_busy = 1'b1;
        shuffle_done = 1'b0;
        case (state)
            S_IDLE: begin
                shuffle_busy = 1'b0;
                if (shuffle_start) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (idx == LAST_IDX) begin
                    state_next = S_PICK;
                end
            end
            S_PICK: begin
                if (accept) begin
                    state_next = S_SWAP;
                end
            end
            S_SWAP: begin
                if (idx > 8'd1) begin
                    state_next = S_PICK;
                end else if (pass < LAST_PASS) begin
                    state_next = S_PICK;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                shuffle_done = 1'b1;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control datapath: fill/shuffle indices, read pointer and the deal port.
    // Starting a shuffle discards whatever is left in the shoe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= 8'd0;
            j_sel      <= '0;
            pass       <= 2'd0;
            fill_r     <= 4'd0;
            ptr        <= 8'd0;
            cards_left <= 8'd0;
            deal_valid <= 1'b0;
            deal_card  <= 4'd0;
        end else begin
            deal_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (shuffle_start) begin
                        idx        <= 8'd0;
                        fill_r     <= 4'd0;
                        cards_left <= 8'd0;
                    end else if (deal_fire) begin
                        deal_valid <= 1'b1;
                        deal_card  <= mem[ptr[AW-1:0]];
                        ptr        <= ptr + 8'd1;
                        cards_left <= cards_left - 8'd1;
                    end
                end
                S_FILL: begin
                    fill_r <= (fill_r == 4'd12) ? 4'd0 : (fill_r + 4'd1);
                    if (idx == LAST_IDX) begin
                        pass <= 2'd0;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                S_PICK: begin
                    if (accept) begin
                        j_sel <= cand[AW-1:0];
                    end
                end
                S_SWAP: begin
                    if (idx > 8'd1) begin
                        idx <= idx - 8'd1;
                    end else if (pass < LAST_PASS) begin
                        pass <= pass + 2'd1;
                        idx  <= LAST_IDX;
                    end
                end
                S_DONE: begin
                    cards_left <= DEPTH_V;
                    ptr        <= 8'd0;
                end
                default: begin
                    deal_valid <= 1'b0;
                end
            endcase
        end
    end

    // Card storage is deliberately not reset; its contents are only trusted
    // after a completed refill and shuffle.
    always_ff @(posedge clock) begin
        if (state == S_FILL) begin
            mem[idx[AW-1:0]] <= canon_value;
        end else if (state == S_SWAP) begin
            mem[idx[AW-1:0]] <= mem[j_sel];
            mem[j_sel]       <= mem[idx[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_sapato_baralho.sv
// ---------------------------------------------------------------------------
// tb_sapato_baralho
//
// Scoreboard bench for sapato_baralho. A single-deck shoe and a four-deck,
// two-pass shoe share clock and reset. Each deal request pushes the expected
// cards_left into a queue; a monitor pops and compares whenever deal_valid
// appears. Shuffle latency is predicted from an independent LFSR model.
// ---------------------------------------------------------------------------
module tb_sapato_baralho;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // Free-running clock, period 10
    always #5 clock = ~clock;

    logic       start1 = 1'b0, req1 = 1'b0;
    logic       busy1, done1, valid1, empty1, low1;
    logic [3:0] card1;
    logic [7:0] left1;

    logic       start4 = 1'b0, req4 = 1'b0;
    logic       busy4, done4, valid4, empty4, low4;
    logic [3:0] card4;
    logic [7:0] left4;

    sapato_baralho #(
        .NUM_DECKS(1), .SHUFFLE_PASSES(1), .LFSR_SEED(16'hACE1), .RESHUFFLE_MARK(16)
    ) dut1 (
        .clock(clock), .reset(reset),
        .shuffle_start(start1), .shuffle_busy(busy1), .shuffle_done(done1),
        .deal_req(req1), .deal_valid(valid1), .deal_card(card1),
        .cards_left(left1), .deal_empty(empty1), .low_shoe(low1)
    );

    sapato_baralho #(
        .NUM_DECKS(4), .SHUFFLE_PASSES(2), .LFSR_SEED(16'hACE1), .RESHUFFLE_MARK(16)
    ) dut4 (
        .clock(clock), .reset(reset),
        .shuffle_start(start4), .shuffle_busy(busy4), .shuffle_done(done4),
        .deal_req(req4), .deal_valid(valid4), .deal_card(card4),
        .cards_left(left4), .deal_empty(empty4), .low_shoe(low4)
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp1[$];
    int exp4[$];
    int cap1[$];
    int cap4[$];
    int lm1 = 0;
    int lm4 = 0;
    int seqA[$];
    int seqB[$];
    int seqC[$];
    logic [15:0] tb_lfsr;

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR, tracks the value each DUT sees at every edge
    always @(posedge clock or posedge reset) begin
        if (reset) tb_lfsr <= 16'hACE1;
        else       tb_lfsr <= lfsrStep(tb_lfsr);
    end

    // Busy-cycle count of a shuffle whose start is sampled with LFSR value l0
    function automatic int modelLatency(input logic [15:0] l0, input int depth, input int passes);
        logic [15:0] l;
        logic [7:0]  c;
        int cyc;
        int m;
        l = l0;
        for (int k = 0; k <= depth; k++) l = lfsrStep(l);
        cyc = depth;
        for (int p = 0; p < passes; p++) begin
            for (int i = depth - 1; i >= 1; i--) begin
                m = 1;
                while (m < i) m = (m << 1) | 1;
                do begin
                    cyc++;
                    c = l[7:0] & 8'(m);
                    l = lfsrStep(l);
                end while (int'(c) > i);
                cyc++;
                l = lfsrStep(l);
            end
        end
        return cyc + 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic busyOf(input int sel);
        return (sel == 1) ? busy1 : busy4;
    endfunction

    function automatic logic doneOf(input int sel);
        return (sel == 1) ? done1 : done4;
    endfunction

    task automatic drive(input int sel, input logic st, input logic rq);
        if (sel == 1) begin start1 = st; req1 = rq; end
        else          begin start4 = st; req4 = rq; end
    endtask

    task automatic applyStimulus(input int sel, input logic st, input logic rq);
        drive(sel, st, rq);
        @(negedge clock);
    endtask

    // Monitor side of the scoreboard
    task automatic scoreDeal(input int sel, input logic [3:0] card, input logic [7:0] left,
                             input logic empty, input logic low);
        int e;
        if ((sel == 1) ? (exp1.size() == 0) : (exp4.size() == 0)) begin
            checkOutput($sformatf("unexpected deal_valid dut%0d", sel), 1, 0);
        end else begin
            e = (sel == 1) ? exp1.pop_front() : exp4.pop_front();
            checkOutput("cards_left on deal", left, e);
            checkOutput("deal_empty on deal", empty, (e == 0) ? 1 : 0);
            checkOutput("low_shoe on deal", low, (e <= 16 && e != 0) ? 1 : 0);
            checkOutput("deal_card in range", (card >= 4'd1 && card <= 4'd11) ? 1 : 0, 1);
            if (sel == 1) cap1.push_back(int'(card));
            else          cap4.push_back(int'(card));
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (valid1) scoreDeal(1, card1, left1, empty1, low1);
            if (valid4) scoreDeal(4, card4, left4, empty4, low4);
        end
    end

    task automatic doReset();
        reset = 1'b1;
        lm1 = 0;
        lm4 = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Reset values, then requests on an empty shoe must be ignored
    task automatic postResetProbe();
        checkOutput("reset busy1", busy1, 0);
        checkOutput("reset done1", done1, 0);
        checkOutput("reset valid1", valid1, 0);
        checkOutput("reset low1", low1, 0);
        checkOutput("reset card1", card1, 0);
        checkOutput("reset left1", left1, 0);
        checkOutput("reset empty1", empty1, 1);
        checkOutput("reset busy4", busy4, 0);
        checkOutput("reset left4", left4, 0);
        checkOutput("reset empty4", empty4, 1);
        for (int k = 0; k < 3; k++) begin
            drive(4, 1'b0, 1'b1);
            applyStimulus(1, 1'b0, 1'b1);
            checkOutput("empty deal_valid1", valid1, 0);
            checkOutput("empty deal_valid4", valid4, 0);
            checkOutput("empty left1", left1, 0);
            checkOutput("empty low1", low1, 0);
        end
        drive(1, 1'b0, 1'b0);
        drive(4, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
    endtask

    task automatic shuffleAndTime(input int sel, input bit inject);
        int depth;
        int expLat;
        int count;
        int dones;
        int doneAt;
        int cyc;
        depth  = (sel == 1) ? 52 : 208;
        expLat = modelLatency(tb_lfsr, depth, (sel == 1) ? 1 : 2);
        applyStimulus(sel, 1'b1, 1'b0);
        drive(sel, 1'b0, 1'b0);
        checkOutput("busy after start", busyOf(sel), 1);
        count = 0; dones = 0; doneAt = 0; cyc = 0;
        while (busyOf(sel) && cyc < 10000) begin
            count++;
            if (doneOf(sel)) begin dones++; doneAt = count; end
            if (inject) drive(sel, (count == 20) || (count == 90), (count == 20) || (count == 60));
            @(negedge clock);
            cyc++;
        end
        drive(sel, 1'b0, 1'b0);
        if (cyc >= 10000) checkOutput("shuffle timeout", 1, 0);
        checkOutput("shuffle latency", count, expLat);
        checkOutput("shuffle_done pulses", dones, 1);
        checkOutput("shuffle_done in last busy cycle", doneAt, count);
        checkOutput("cards_left after done", (sel == 1) ? left1 : left4, depth);
        checkOutput("deal_empty after done", (sel == 1) ? empty1 : empty4, 0);
        if (sel == 1) lm1 = depth; else lm4 = depth;
    endtask

    task automatic dealCards(input int sel, input int n);
        for (int k = 0; k < n; k++) begin
            if (sel == 1) begin
                if (lm1 > 0) begin lm1--; exp1.push_back(lm1); end
            end else begin
                if (lm4 > 0) begin lm4--; exp4.push_back(lm4); end
            end
            applyStimulus(sel, 1'b0, 1'b1);
        end
        drive(sel, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        checkOutput("scoreboard drained", (sel == 1) ? exp1.size() : exp4.size(), 0);
    endtask

    task automatic checkHistogram(input int sel, input int decks);
        int h[12];
        for (int v = 0; v < 12; v++) h[v] = 0;
        if (sel == 1) foreach (cap1[k]) if (cap1[k] >= 0 && cap1[k] < 12) h[cap1[k]]++;
        if (sel == 4) foreach (cap4[k]) if (cap4[k] >= 0 && cap4[k] < 12) h[cap4[k]]++;
        for (int v = 1; v <= 10; v++) checkOutput($sformatf("histogram value %0d", v), h[v], 4 * decks);
        checkOutput("histogram value 11", h[11], 12 * decks);
    endtask

    function automatic int seqDiffs(input int a[$], input int b[$]);
        int d;
        d = (a.size() == b.size()) ? 0 : 1000;
        for (int k = 0; k < a.size() && k < b.size(); k++) if (a[k] != b[k]) d++;
        return d;
    endfunction

    initial begin
        doReset();
        postResetProbe();

        // First shuffle and full deal of a single deck
        shuffleAndTime(1, 1'b0);
        cap1.delete();
        dealCards(1, 52);
        checkOutput("cards dealt", cap1.size(), 52);
        checkHistogram(1, 1);
        seqA = cap1;
        cap1.delete();
        checkOutput("empty after last card", empty1, 1);
        applyStimulus(1, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0);
        checkOutput("53rd deal_valid", valid1, 0);
        checkOutput("53rd cards_left", left1, 0);
        if (seqA.size() == 52) checkOutput("deal_card holds", card1, seqA[51]);

        // Shuffle with ignored start/deal pulses while busy
        shuffleAndTime(1, 1'b1);
        dealCards(1, 52);
        seqC = cap1;
        cap1.delete();
        checkOutput("second shuffle differs", (seqDiffs(seqA, seqC) != 0) ? 1 : 0, 1);

        // Asynchronous reset in the middle of a shuffle
        applyStimulus(1, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (30) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset busy", busy1, 0);
        checkOutput("async reset cards_left", left1, 0);
        checkOutput("async reset deal_empty", empty1, 1);
        doReset();
        postResetProbe();

        // Same cycle timing after reset must reproduce the first sequence
        shuffleAndTime(1, 1'b0);
        dealCards(1, 52);
        seqB = cap1;
        cap1.delete();
        checkOutput("repeat sequence diffs", seqDiffs(seqA, seqB), 0);

        // Four decks, two passes
        shuffleAndTime(4, 1'b0);
        cap4.delete();
        dealCards(4, 208);
        checkOutput("cards dealt dut4", cap4.size(), 208);
        checkHistogram(4, 4);
        checkOutput("dut4 empty at end", empty4, 1);
        checkOutput("dut4 cards_left at end", left4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
